// File: rtl/issue_select.sv
// Issue select stage: picks up to N ready reservation-station entries per
// cycle in round-robin order, bounded by per-FU-class slot budgets. The grant
// vector goes back to the RS combinationally; the chosen packets are
// registered into the issue->execute register.

package issue_select_pkg;
  localparam int B_MASK_W = 4;
  localparam int SQ_W     = 4;
  localparam int TAG_W    = 8;

  localparam logic [1:0] FU_ALU  = 2'd0;
  localparam logic [1:0] FU_MULT = 2'd1;
  localparam logic [1:0] FU_MEM  = 2'd2;
  localparam logic [1:0] FU_BR   = 2'd3;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic                Source1_ready;
    logic                Source2_ready;
    logic [1:0]          fu_type;
    logic [SQ_W-1:0]     sq_mask;
    logic [B_MASK_W-1:0] b_mask;
  } RS_PACKET;
endpackage

module issue_select
  import issue_select_pkg::*;
#(
  parameter int RS_SZ    = 8,
  parameter int N        = 2,
  parameter int NUM_FU_T = 4,
  parameter int PTR_W    = $clog2(RS_SZ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  RS_PACKET [RS_SZ-1:0]  rs_data_next,
  input  logic [RS_SZ-1:0]      rs_valid_issue,
  input  logic [NUM_FU_T*2-1:0] fu_slots,
  input  logic [B_MASK_W-1:0]   b_mm_resolve,
  input  logic                  b_mm_mispred,
  output logic [RS_SZ-1:0]      rs_data_issuing,
  output RS_PACKET [N-1:0]      is_packets,
  output logic [N-1:0]          is_valid
);

  logic [PTR_W-1:0] r_rr_ptr;
  RS_PACKET [N-1:0] r_is_packets;
  logic [N-1:0]     r_is_valid;

  logic [RS_SZ-1:0] w_ready;
  logic [RS_SZ-1:0] w_grant;
  logic [PTR_W-1:0] w_slot_idx [N];
  logic [N-1:0]     w_slot_vld;
  logic             w_any;
  logic [PTR_W-1:0] w_rr_next;
  RS_PACKET [N-1:0] w_pkt_next;
  logic [N-1:0]     w_vld_next;

  // Per-entry readiness: valid, both sources ready, memory ops wait for an empty sq_mask
  always_comb begin
    w_ready = '0;
    for (int j = 0; j < RS_SZ; j++) begin
      if (rs_valid_issue[j] && rs_data_next[j].Source1_ready && rs_data_next[j].Source2_ready &&
          ((rs_data_next[j].fu_type != FU_MEM) || (rs_data_next[j].sq_mask == '0))) begin
        w_ready[j] = 1'b1;
      end else begin
        w_ready[j] = 1'b0;
      end
    end
  end

  // Round-robin scan from r_rr_ptr, granting under the total and per-class budgets
  always_comb begin
    int         total;
    int         last;
    int         idx;
    int         cls_cnt [NUM_FU_T];
    logic [PTR_W-1:0] j;
    logic [1:0] cls;
    w_grant    = '0;
    w_slot_vld = '0;
    w_any      = 1'b0;
    w_rr_next  = r_rr_ptr;
    total      = 0;
    last       = 0;
    idx        = 0;
    j          = '0;
    cls        = 2'd0;
    for (int s = 0; s < N; s++) begin
      w_slot_idx[s] = '0;
    end
    for (int c = 0; c < NUM_FU_T; c++) begin
      cls_cnt[c] = 0;
    end
    for (int k = 0; k < RS_SZ; k++) begin
      idx = (int'(r_rr_ptr) + k) % RS_SZ;
      j   = PTR_W'(idx);
      cls = rs_data_next[j].fu_type;
      if (w_ready[j] && (total < N) && (cls_cnt[cls] < int'(fu_slots[{cls, 1'b0} +: 2]))) begin
        w_grant[j] = 1'b1;
        for (int s = 0; s < N; s++) begin
          if (s == total) begin
            w_slot_idx[s] = j;
            w_slot_vld[s] = 1'b1;
          end else begin
            w_slot_vld[s] = w_slot_vld[s];
          end
        end
        cls_cnt[cls] = cls_cnt[cls] + 1;
        total        = total + 1;
        last         = idx;
        w_any        = 1'b1;
      end else begin
        w_grant[j] = 1'b0;
      end
    end
    if (w_any) begin
      w_rr_next = PTR_W'((last + 1) % RS_SZ);
    end else begin
      w_rr_next = r_rr_ptr;
    end
  end

  // Next issue-register image: fresh grants load as-is; leftover slots go
  // invalid, and their stale packet is zeroed on a mispredict or has the
  // resolved branch bit cleared otherwise
  always_comb begin
    w_pkt_next = r_is_packets;
    w_vld_next = '0;
    for (int s = 0; s < N; s++) begin
      if (w_slot_vld[s]) begin
        w_pkt_next[s] = rs_data_next[w_slot_idx[s]];
        w_vld_next[s] = 1'b1;
      end else if (b_mm_mispred && ((r_is_packets[s].b_mask & b_mm_resolve) != '0)) begin
        w_pkt_next[s] = '0;
        w_vld_next[s] = 1'b0;
      end else begin
        w_pkt_next[s].b_mask = r_is_packets[s].b_mask & ~b_mm_resolve;
        w_vld_next[s]        = 1'b0;
      end
    end
  end

  // Pointer and issue register update; reset discards everything in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_is_packets <= '0;
      r_is_valid   <= '0;
    end else begin
      r_rr_ptr     <= w_rr_next;
      r_is_packets <= w_pkt_next;
      r_is_valid   <= w_vld_next;
    end
  end

  assign rs_data_issuing = w_grant;
  assign is_packets      = r_is_packets;
  assign is_valid        = r_is_valid;

endmodule
